// File: rtl/rgb_pwm_driver_pkg.sv
// Shared definitions for the RGB PWM driver: channel width, channel slice
// positions inside the packed 24-bit code, and named colours that match the
// upstream converter table.
package rgb_pwm_driver_pkg;

  localparam int RGB_CH_W     = 8;
  localparam int RGB_PRESCALE = 1;

  localparam int R_MSB = 3*RGB_CH_W - 1;
  localparam int R_LSB = 2*RGB_CH_W;
  localparam int G_MSB = 2*RGB_CH_W - 1;
  localparam int G_LSB = RGB_CH_W;
  localparam int B_MSB = RGB_CH_W - 1;
  localparam int B_LSB = 0;

  localparam logic [3*RGB_CH_W-1:0] COL_BLACK  = 24'h000000;
  localparam logic [3*RGB_CH_W-1:0] COL_RED    = 24'hFF0000;
  localparam logic [3*RGB_CH_W-1:0] COL_GREEN  = 24'h00FF00;
  localparam logic [3*RGB_CH_W-1:0] COL_BLUE   = 24'h0000FF;
  localparam logic [3*RGB_CH_W-1:0] COL_ORANGE = 24'hFF8000;
  localparam logic [3*RGB_CH_W-1:0] COL_GREY   = 24'h404040;
  localparam logic [3*RGB_CH_W-1:0] COL_WHITE  = 24'hFFFFFF;

endpackage

// File: rtl/rgb_pwm_channel.sv
// One PWM output: the LED is high while the shared period counter is below
// this channel's duty value. Registered, so it lags the counter by one clk.
module rgb_pwm_channel #(
  parameter int CH_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [CH_W-1:0] cnt,
  input  logic [CH_W-1:0] duty,
  output logic            led
);

  // Compare counter against duty every clk; forced low while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led <= 1'b0;
    else        led <= enable && (cnt < duty);
  end

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel LED PWM driver. New colour codes land in a shadow register
// and are promoted to the active duty registers only at a period boundary
// (or at once while disabled), so an LED never sees a partial period.
module rgb_pwm_driver
  import rgb_pwm_driver_pkg::*;
#(
  parameter int CH_W     = RGB_CH_W,
  parameter int PRESCALE = RGB_PRESCALE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              rgb_valid,
  input  logic [3*CH_W-1:0] rgb,
  output logic              led_r,
  output logic              led_g,
  output logic              led_b,
  output logic              period_start,
  output logic              load_ack
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [CH_W-1:0]  CNT_LAST = {CH_W{1'b1}};

  logic [PRE_W-1:0]  pre;
  logic [CH_W-1:0]   pwm_cnt;
  logic [3*CH_W-1:0] shadow;
  logic [3*CH_W-1:0] active;
  logic              pending;
  logic              tick;
  logic              boundary;
  logic              load_now;

  assign tick     = enable && (pre == PRE_LAST);
  assign boundary = tick && (pwm_cnt == CNT_LAST);
  // A disabled driver has no period in flight, so any pending code may load.
  assign load_now = pending && (boundary || !enable);

  // Prescaler: divides clk down to PWM ticks; held at 0 while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        pre <= '0;
    else if (!enable || pre == PRE_LAST) pre <= '0;
    else                               pre <= pre + PRE_W'(1);
  end

  // Period counter: advances one step per tick, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pwm_cnt <= '0;
    else if (!enable) pwm_cnt <= '0;
    else if (tick)    pwm_cnt <= pwm_cnt + CH_W'(1);
  end

  // Double buffer: capture is unconditional (last strobe wins); promotion
  // reads the shadow value from before this clk's capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      if (load_now)  active <= shadow;
      if (rgb_valid) begin
        shadow  <= rgb;
        pending <= 1'b1;
      end else if (load_now) begin
        pending <= 1'b0;
      end
    end
  end

  // Status pulses, registered to line up with the LED outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_start <= 1'b0;
      load_ack     <= 1'b0;
    end else begin
      period_start <= enable && (pwm_cnt == '0) && (pre == '0);
      load_ack     <= load_now;
    end
  end

  rgb_pwm_channel #(.CH_W(CH_W)) u_ch_r (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .cnt    (pwm_cnt),
    .duty   (active[3*CH_W-1:2*CH_W]),
    .led    (led_r)
  );

  rgb_pwm_channel #(.CH_W(CH_W)) u_ch_g (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .cnt    (pwm_cnt),
    .duty   (active[2*CH_W-1:CH_W]),
    .led    (led_g)
  );

  rgb_pwm_channel #(.CH_W(CH_W)) u_ch_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .cnt    (pwm_cnt),
    .duty   (active[CH_W-1:0]),
    .led    (led_b)
  );

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: a PRESCALE=1 instance tracked by a period-position
// reference model, plus a PRESCALE=4 instance for the divided-clock scenario.
module tb_rgb_pwm_driver;
  import rgb_pwm_driver_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        rgb_valid = 1'b0;
  logic [23:0] rgb = '0;

  logic led_r, led_g, led_b, period_start, load_ack;
  logic r4, g4, b4, ps4, ack4;

  int n_tests = 0;
  int n_failed = 0;

  // reference model state: enabled edges since last disabled edge, buffers
  int          m_pos = 0;
  logic [23:0] m_shadow = '0, m_active = '0;
  logic        m_pending = 1'b0;
  logic        exp_r, exp_g, exp_b, exp_ps, exp_ack;

  always #5 clk = ~clk;

  rgb_pwm_driver #(.CH_W(8), .PRESCALE(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rgb_valid(rgb_valid), .rgb(rgb),
    .led_r(led_r), .led_g(led_g), .led_b(led_b),
    .period_start(period_start), .load_ack(load_ack)
  );

  rgb_pwm_driver #(.CH_W(8), .PRESCALE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rgb_valid(rgb_valid), .rgb(rgb),
    .led_r(r4), .led_g(g4), .led_b(b4),
    .period_start(ps4), .load_ack(ack4)
  );

  task automatic model_reset();
    m_pos = 0; m_shadow = '0; m_active = '0; m_pending = 1'b0;
  endtask

  // Drive one clk of stimulus and predict what the outputs show after it.
  task automatic step(input logic en, input logic v, input logic [23:0] code);
    int  pos;
    logic bnd, ld;
    enable = en; rgb_valid = v; rgb = code;
    pos = m_pos % 256;
    bnd = en && (pos == 255);
    ld  = m_pending && (bnd || !en);
    exp_r   = en && (pos < int'(m_active[R_MSB:R_LSB]));
    exp_g   = en && (pos < int'(m_active[G_MSB:G_LSB]));
    exp_b   = en && (pos < int'(m_active[B_MSB:B_LSB]));
    exp_ps  = en && (pos == 0);
    exp_ack = ld;
    if (ld) m_active = m_shadow;
    if (v) begin m_shadow = code; m_pending = 1'b1; end
    else if (ld) m_pending = 1'b0;
    m_pos = en ? m_pos + 1 : 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    n_tests++;
    if ({led_r, led_g, led_b, period_start, load_ack, r4, g4, b4, ps4, ack4} !== 10'b0) begin
      n_failed++;
      $display("FAIL reset_outputs: got %b want 0000000000",
               {led_r, led_g, led_b, period_start, load_ack, r4, g4, b4, ps4, ack4});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    int hr = 0, hg = 0, hb = 0, acks = 0;
    bit got = 0;
    step(1'b1, 1'b1, COL_ORANGE);
    n_tests++;
    if (period_start !== 1'b1) begin
      n_failed++; $display("FAIL basic_first_ps: got %b want 1", period_start);
    end
    for (int i = 0; i < 600 && !got; i++) begin
      step(1'b1, 1'b0, '0);
      n_tests++;
      if ({led_r, led_g, led_b, period_start, load_ack} !== {exp_r, exp_g, exp_b, exp_ps, exp_ack}) begin
        n_failed++;
        $display("FAIL basic_cycle: got %b want %b", {led_r, led_g, led_b, period_start, load_ack},
                 {exp_r, exp_g, exp_b, exp_ps, exp_ack});
      end
      if (load_ack) got = 1;
    end
    n_tests++;
    if (!got) begin n_failed++; $display("FAIL basic_ack_timeout: got no load_ack want one"); end
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 1'b0, '0);
      hr += int'(led_r); hg += int'(led_g); hb += int'(led_b); acks += int'(load_ack);
    end
    n_tests++;
    if (hr != 255 || hg != 128 || hb != 0 || acks != 0) begin
      n_failed++;
      $display("FAIL basic_duty: got r=%0d g=%0d b=%0d acks=%0d want r=255 g=128 b=0 acks=0", hr, hg, hb, acks);
    end
  endtask

  task automatic test_double_strobe();
    int acks = 0, hr = 0, hg = 0, hb = 0, guard = 0;
    while (m_pos % 256 != 100 && guard < 300) begin step(1'b1, 1'b0, '0); guard++; end
    step(1'b1, 1'b1, COL_BLUE);
    for (int i = 0; i < 300; i++) begin
      step(1'b1, (i == 49), COL_GREEN);
      acks += int'(load_ack);
      n_tests++;
      if ({led_r, led_g, led_b, load_ack} !== {exp_r, exp_g, exp_b, exp_ack}) begin
        n_failed++;
        $display("FAIL double_cycle: got %b want %b", {led_r, led_g, led_b, load_ack},
                 {exp_r, exp_g, exp_b, exp_ack});
      end
    end
    n_tests++;
    if (acks != 1) begin n_failed++; $display("FAIL double_ack_count: got %0d want 1", acks); end
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 1'b0, '0);
      hr += int'(led_r); hg += int'(led_g); hb += int'(led_b);
    end
    n_tests++;
    if (hr != 0 || hg != 255 || hb != 0) begin
      n_failed++; $display("FAIL double_duty: got r=%0d g=%0d b=%0d want r=0 g=255 b=0", hr, hg, hb);
    end
  endtask

  task automatic test_boundary_strobe();
    int hr = 0, hg = 0, hb = 0, acks = 0, guard = 0;
    logic last_ack = 1'b0;
    while (m_pos % 256 != 50 && guard < 300) begin step(1'b1, 1'b0, '0); guard++; end
    step(1'b1, 1'b1, 24'h800000);
    guard = 0;
    while (m_pos % 256 != 255 && guard < 300) begin step(1'b1, 1'b0, '0); guard++; end
    step(1'b1, 1'b1, 24'h0040C0);
    n_tests++;
    if (load_ack !== 1'b1) begin n_failed++; $display("FAIL bnd_first_ack: got %b want 1", load_ack); end
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 1'b0, '0);
      hr += int'(led_r); hg += int'(led_g); hb += int'(led_b); acks += int'(load_ack);
      last_ack = load_ack;
    end
    n_tests++;
    if (hr != 128 || hg != 0 || hb != 0 || acks != 1 || last_ack !== 1'b1) begin
      n_failed++;
      $display("FAIL bnd_old_period: got r=%0d g=%0d b=%0d acks=%0d last=%b want r=128 g=0 b=0 acks=1 last=1",
               hr, hg, hb, acks, last_ack);
    end
    hr = 0; hg = 0; hb = 0;
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 1'b0, '0);
      hr += int'(led_r); hg += int'(led_g); hb += int'(led_b);
    end
    n_tests++;
    if (hr != 0 || hg != 64 || hb != 192) begin
      n_failed++; $display("FAIL bnd_new_period: got r=%0d g=%0d b=%0d want r=0 g=64 b=192", hr, hg, hb);
    end
  endtask

  task automatic test_prescale();
    int seen = 0, n = 0, hr = 0, hg = 0, hb = 0, guard = 0;
    step(1'b1, 1'b1, COL_GREY);
    while (seen < 2 && guard < 2500) begin
      step(1'b1, 1'b0, '0);
      if (ps4) seen++;
      guard++;
    end
    n_tests++;
    if (seen < 2) begin n_failed++; $display("FAIL pre4_ps_timeout: got %0d period_start want 2", seen); end
    n = 1; hr = int'(r4); hg = int'(g4); hb = int'(b4);
    guard = 0;
    while (guard < 1100) begin
      step(1'b1, 1'b0, '0);
      guard++;
      if (ps4) break;
      n++; hr += int'(r4); hg += int'(g4); hb += int'(b4);
    end
    n_tests++;
    if (n != 1024) begin n_failed++; $display("FAIL pre4_period: got %0d clks want 1024", n); end
    n_tests++;
    if (hr != 256 || hg != 256 || hb != 256) begin
      n_failed++; $display("FAIL pre4_duty: got r=%0d g=%0d b=%0d want 256 each", hr, hg, hb);
    end
  endtask

  task automatic test_disable();
    int hb = 0, guard = 0;
    bit got = 0;
    step(1'b1, 1'b1, COL_RED);
    for (int i = 0; i < 600 && !got; i++) begin step(1'b1, 1'b0, '0); if (load_ack) got = 1; end
    while (led_r !== 1'b1 && guard < 10) begin step(1'b1, 1'b0, '0); guard++; end
    n_tests++;
    if (!got || led_r !== 1'b1) begin
      n_failed++; $display("FAIL dis_setup: got ack=%0d led_r=%b want ack=1 led_r=1", got, led_r);
    end
    step(1'b0, 1'b0, '0);
    n_tests++;
    if ({led_r, led_g, led_b, period_start} !== 4'b0) begin
      n_failed++; $display("FAIL dis_leds_off: got %b want 0000", {led_r, led_g, led_b, period_start});
    end
    step(1'b0, 1'b1, COL_BLUE);
    step(1'b0, 1'b0, '0);
    n_tests++;
    if (load_ack !== 1'b1) begin n_failed++; $display("FAIL dis_load_ack: got %b want 1", load_ack); end
    step(1'b1, 1'b0, '0);
    n_tests++;
    if ({period_start, led_r, led_b} !== 3'b101) begin
      n_failed++; $display("FAIL dis_restart: got ps,r,b=%b want 101", {period_start, led_r, led_b});
    end
    hb = int'(led_b);
    for (int i = 0; i < 255; i++) begin step(1'b1, 1'b0, '0); hb += int'(led_b); end
    n_tests++;
    if (hb != 255) begin n_failed++; $display("FAIL dis_restart_duty: got b=%0d want 255", hb); end
  endtask

  task automatic test_async_reset();
    int acks = 0, highs = 0, guard = 0;
    while ((m_pos % 256 < 10 || m_pos % 256 > 200) && guard < 300) begin step(1'b1, 1'b0, '0); guard++; end
    step(1'b1, 1'b1, COL_WHITE);
    step(1'b1, 1'b0, '0);
    n_tests++;
    if (led_b !== 1'b1) begin n_failed++; $display("FAIL arst_pre_led: got %b want 1", led_b); end
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({led_r, led_g, led_b, period_start, load_ack, r4, g4, b4, ps4, ack4} !== 10'b0) begin
      n_failed++;
      $display("FAIL arst_outputs: got %b want 0000000000",
               {led_r, led_g, led_b, period_start, load_ack, r4, g4, b4, ps4, ack4});
    end
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    for (int i = 0; i < 600; i++) begin
      step(1'b1, 1'b0, '0);
      acks += int'(load_ack); highs += int'(led_r) + int'(led_g) + int'(led_b);
    end
    n_tests++;
    if (acks != 0 || highs != 0) begin
      n_failed++; $display("FAIL arst_pending_lost: got acks=%0d highs=%0d want 0 0", acks, highs);
    end
  endtask

  task automatic test_random();
    logic en = 1'b1;
    logic v;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 2) en = ~en;
      v = ($urandom_range(0, 99) < 4);
      step(en, v, 24'($urandom()));
      n_tests++;
      if ({led_r, led_g, led_b, period_start, load_ack} !== {exp_r, exp_g, exp_b, exp_ps, exp_ack}) begin
        n_failed++;
        $display("FAIL random_cycle %0d: got %b want %b", i, {led_r, led_g, led_b, period_start, load_ack},
                 {exp_r, exp_g, exp_b, exp_ps, exp_ack});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_double_strobe();
    test_boundary_strobe();
    test_prescale();
    test_disable();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
